// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit port among Nreq requesters.
// Each grant is held for a whole packet, or cut after MaxBurst bytes when others are waiting.
module uart_tx_arbiter #(
   parameter int Nreq     = 4,
   parameter int Wdata    = 8,
   parameter int MaxBurst = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [Nreq-1:0]       req,
   input  logic [Nreq*Wdata-1:0] data,
   input  logic [Nreq-1:0]       last,
   output logic [Nreq-1:0]       gnt,
   output logic [Nreq-1:0]       ack,
   output logic [Wdata-1:0]      uart_din,
   output logic                  uart_oe,
   input  logic                  uart_rdy
);

   localparam int Wptr = $clog2(Nreq);
   localparam int Wcnt = (MaxBurst > 0) ? $clog2(MaxBurst + 1) : 1;
   localparam logic [Wcnt-1:0] CntMax = Wcnt'(MaxBurst);

   typedef enum logic [1:0] {IDLE, GRANT, WAIT_LO, WAIT_HI} state_t;

   state_t            state, state_nxt;
   logic [Wptr-1:0]   owner, owner_nxt;
   logic [Wptr-1:0]   ptr, ptr_nxt;
   logic [Wcnt-1:0]   cnt, cnt_nxt;
   logic              l, l_nxt;
   logic [Nreq-1:0]   gnt_nxt, ack_nxt;
   logic [Wdata-1:0]  din_nxt;
   logic              oe_nxt;

   logic              found;
   logic [Wptr-1:0]   pick, scan;
   logic [Wdata-1:0]  sel_data;
   logic              sel_last;
   logic              own_req, others_req;

   function automatic logic [Wptr-1:0] next_idx(input logic [Wptr-1:0] i);
      return (int'(i) == Nreq - 1) ? '0 : i + 1'b1;
   endfunction

   // First requester at or after ptr, wrapping modulo Nreq.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      scan  = ptr;
      for (int k = 0; k < Nreq; k++) begin
         if (!found && req[scan]) begin
            found = 1'b1;
            pick  = scan;
         end
         scan = next_idx(scan);
      end
   end

   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      for (int i = 0; i < Nreq; i++) begin
         if (gnt[i]) begin
            sel_data = data[i*Wdata +: Wdata];
            sel_last = last[i];
         end
      end
      own_req    = |(req & gnt);
      others_req = |(req & ~gnt);
   end

   // NOTE: every output of this block gets a default before the case, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      l_nxt     = l;
      gnt_nxt   = gnt;
      ack_nxt   = '0;
      din_nxt   = uart_din;
      oe_nxt    = 1'b0;

      case (state)
         IDLE: begin
            if (found) begin
               gnt_nxt   = {{(Nreq-1){1'b0}}, 1'b1} << pick;
               owner_nxt = pick;
               cnt_nxt   = '0;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (!own_req) begin
               gnt_nxt   = '0;
               ptr_nxt   = next_idx(owner);
               state_nxt = IDLE;
            end else if (uart_rdy) begin
               oe_nxt    = 1'b1;
               din_nxt   = sel_data;
               ack_nxt   = gnt;
               l_nxt     = sel_last;
               cnt_nxt   = (cnt == CntMax) ? cnt : cnt + 1'b1;
               state_nxt = WAIT_LO;
            end
         end
         WAIT_LO: begin
            if (!uart_rdy) state_nxt = WAIT_HI;
         end
         WAIT_HI: begin
            if (uart_rdy) begin
               if (l || (MaxBurst != 0 && cnt == CntMax && others_req)) begin
                  gnt_nxt   = '0;
                  ptr_nxt   = next_idx(owner);
                  state_nxt = IDLE;
               end else begin
                  state_nxt = GRANT;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         owner    <= '0;
         ptr      <= '0;
         cnt      <= '0;
         l        <= 1'b0;
         gnt      <= '0;
         ack      <= '0;
         uart_din <= '0;
         uart_oe  <= 1'b0;
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         ptr      <= ptr_nxt;
         cnt      <= cnt_nxt;
         l        <= l_nxt;
         gnt      <= gnt_nxt;
         ack      <= ack_nxt;
         uart_din <= din_nxt;
         uart_oe  <= oe_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: packet requesters and a UART model drive two
// instances (unlimited burst and MaxBurst=2); transmitted bytes are logged and checked.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] data;
   logic [3:0]  last;
   logic        uart_rdy;

   logic [3:0]  gnt0, ack0, gnt2, ack2;
   logic [7:0]  din0, din2;
   logic        oe0, oe2;

   logic [3:0]  o_gnt, o_ack;
   logic [7:0]  o_din;
   logic        o_oe;
   bit          use_mb = 1'b0;

   int          n_tests = 0;
   int          n_fail  = 0;

   logic [8:0]  pkt [4][32];
   int          head [4];
   int          tail [4];
   logic [7:0]  log_din [64];
   logic [3:0]  log_gnt [64];
   logic [3:0]  log_ack [64];
   int          tx_n;
   int          viol;
   int          busy;
   bit          auto_uart = 1'b1;
   logic        man_rdy   = 1'b1;
   int          base;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.Nreq(4), .Wdata(8), .MaxBurst(0)) dut0 (
      .clk(clk), .rst(rst), .req(req), .data(data), .last(last),
      .gnt(gnt0), .ack(ack0), .uart_din(din0), .uart_oe(oe0), .uart_rdy(uart_rdy)
   );

   uart_tx_arbiter #(.Nreq(4), .Wdata(8), .MaxBurst(2)) dut2 (
      .clk(clk), .rst(rst), .req(req), .data(data), .last(last),
      .gnt(gnt2), .ack(ack2), .uart_din(din2), .uart_oe(oe2), .uart_rdy(uart_rdy)
   );

   assign o_gnt = use_mb ? gnt2 : gnt0;
   assign o_ack = use_mb ? ack2 : ack0;
   assign o_din = use_mb ? din2 : din0;
   assign o_oe  = use_mb ? oe2  : oe0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Requester queues and UART model, all acting on the falling edge.
   initial begin
      busy     = 0;
      tx_n     = 0;
      viol     = 0;
      uart_rdy = 1'b1;
      req      = '0;
      data     = '0;
      last     = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            busy = 0;
            for (int i = 0; i < 4; i++) head[i] = tail[i];
         end else begin
            if (o_oe) begin
               if (busy != 0) viol++;
               if (tx_n < 64) begin
                  log_din[tx_n] = o_din;
                  log_gnt[tx_n] = o_gnt;
                  log_ack[tx_n] = o_ack;
               end
               tx_n++;
               busy = 3;
            end
            if ($countones(o_gnt) > 1 || $countones(o_ack) > 1) viol++;
            for (int i = 0; i < 4; i++)
               if (o_ack[i] && head[i] != tail[i]) head[i]++;
         end
         uart_rdy = auto_uart ? (busy == 0) : man_rdy;
         if (busy > 0) busy--;
         for (int i = 0; i < 4; i++) begin
            req[i]         = (head[i] != tail[i]);
            data[i*8 +: 8] = pkt[i][head[i][4:0]][7:0];
            last[i]        = pkt[i][head[i][4:0]][8];
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic push(input int i, input logic [7:0] d, input logic l);
      pkt[i][tail[i][4:0]] = {l, d};
      tail[i]++;
   endtask

   function automatic bit all_empty();
      for (int i = 0; i < 4; i++)
         if (head[i] != tail[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_done(input string tag, input int n);
      int k = 0;
      while (k < 500 && !(tx_n >= n && o_gnt == 4'b0000 && all_empty())) begin
         step();
         k++;
      end
      check({tag, "_done"}, 32'(k < 500), 32'd1);
   endtask

   task automatic expect_tx(input string tag, input int idx, input logic [7:0] d, input logic [3:0] g);
      check({tag, "_din"}, log_din[idx], d);
      check({tag, "_gnt"}, log_gnt[idx], g);
      check({tag, "_ack"}, log_ack[idx], g);
   endtask

   task automatic do_reset(input bit mb);
      use_mb    = mb;
      auto_uart = 1'b1;
      man_rdy   = 1'b1;
      rst       = 1'b0;
      step();
      step();
      check("rst_gnt", o_gnt, 4'b0000);
      check("rst_ack", o_ack, 4'b0000);
      check("rst_oe",  o_oe,  1'b0);
      check("rst_din", o_din, 8'h00);
      rst = 1'b1;
   endtask

   initial begin
      int k;
      rst = 1'b0;

      // 1: single byte from requester 0, cycle-exact handshake.
      do_reset(1'b0);
      base = tx_n;
      push(0, 8'h41, 1'b1);
      step();
      check("t1_gnt_p0", o_gnt, 4'b0000);
      step();
      check("t1_gnt_p1", o_gnt, 4'b0001);
      check("t1_oe_p1",  o_oe,  1'b0);
      step();
      check("t1_oe_p2",  o_oe,  1'b1);
      check("t1_din_p2", o_din, 8'h41);
      check("t1_ack_p2", o_ack, 4'b0001);
      step();
      check("t1_oe_p3",  o_oe,  1'b0);
      check("t1_ack_p3", o_ack, 4'b0000);
      check("t1_gnt_p3", o_gnt, 4'b0001);
      wait_done("t1", base + 1);
      check("t1_count", tx_n - base, 1);

      // Pointer moved to 1: requester 1 wins over 0.
      base = tx_n;
      push(0, 8'h50, 1'b1);
      push(1, 8'h51, 1'b1);
      step();
      step();
      check("t1_ptr_gnt", o_gnt, 4'b0010);
      wait_done("t1_ptr", base + 2);
      expect_tx("t1_ptr_a", base,     8'h51, 4'b0010);
      expect_tx("t1_ptr_b", base + 1, 8'h50, 4'b0001);

      // 2: all four requesting, one-byte packets, round-robin.
      do_reset(1'b0);
      base = tx_n;
      for (int i = 0; i < 4; i++) push(i, 8'h60 + 8'(i), 1'b1);
      push(0, 8'h70, 1'b1);
      wait_done("t2", base + 5);
      expect_tx("t2_0", base,     8'h60, 4'b0001);
      expect_tx("t2_1", base + 1, 8'h61, 4'b0010);
      expect_tx("t2_2", base + 2, 8'h62, 4'b0100);
      expect_tx("t2_3", base + 3, 8'h63, 4'b1000);
      expect_tx("t2_4", base + 4, 8'h70, 4'b0001);

      // 3: packet "ABC" from requester 2 is not interleaved with requester 0.
      base = tx_n;
      push(2, 8'h41, 1'b0);
      push(2, 8'h42, 1'b0);
      push(2, 8'h43, 1'b1);
      step();
      step();
      check("t3_gnt", o_gnt, 4'b0100);
      push(0, 8'h30, 1'b1);
      wait_done("t3", base + 4);
      expect_tx("t3_a", base,     8'h41, 4'b0100);
      expect_tx("t3_b", base + 1, 8'h42, 4'b0100);
      expect_tx("t3_c", base + 2, 8'h43, 4'b0100);
      expect_tx("t3_0", base + 3, 8'h30, 4'b0001);

      // 4: MaxBurst=2 splits a 5-byte packet around a waiting requester 3.
      do_reset(1'b1);
      base = tx_n;
      for (int i = 0; i < 5; i++) push(1, 8'h11 + 8'(i), i == 4);
      push(3, 8'h33, 1'b1);
      wait_done("t4", base + 6);
      expect_tx("t4_0", base,     8'h11, 4'b0010);
      expect_tx("t4_1", base + 1, 8'h12, 4'b0010);
      expect_tx("t4_2", base + 2, 8'h33, 4'b1000);
      expect_tx("t4_3", base + 3, 8'h13, 4'b0010);
      expect_tx("t4_4", base + 4, 8'h14, 4'b0010);
      expect_tx("t4_5", base + 5, 8'h15, 4'b0010);

      // 5: transmitter busy for 100 cycles, then exactly one byte.
      do_reset(1'b0);
      base      = tx_n;
      auto_uart = 1'b0;
      man_rdy   = 1'b0;
      push(0, 8'h55, 1'b1);
      repeat (100) step();
      check("t5_no_oe", tx_n - base, 0);
      check("t5_gnt",   o_gnt, 4'b0001);
      auto_uart = 1'b1;
      wait_done("t5", base + 1);
      check("t5_count", tx_n - base, 1);
      check("t5_din",   log_din[base], 8'h55);

      // 6: reset while waiting for the transmitter to finish.
      do_reset(1'b0);
      push(3, 8'h77, 1'b0);
      push(3, 8'h78, 1'b1);
      k = 0;
      while (!o_oe && k < 50) begin
         step();
         k++;
      end
      check("t6_oe_seen", o_oe, 1'b1);
      step();
      rst = 1'b0;
      step();
      check("t6_gnt", o_gnt, 4'b0000);
      check("t6_ack", o_ack, 4'b0000);
      check("t6_oe",  o_oe,  1'b0);
      rst  = 1'b1;
      base = tx_n;
      push(3, 8'h79, 1'b1);
      step();
      step();
      check("t6_regrant", o_gnt, 4'b1000);
      wait_done("t6", base + 1);
      check("t6_din", log_din[base], 8'h79);

      check("protocol", viol, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
